accel_cmd_sequencer: RTL

Initiator for the custom-instruction accelerator command/response interface. It accepts a batch job (function ID plus command count) and streams operand pairs from an upstream source as commands to `user_def_accelerator`. It collects the single-word responses in order, forwards them on a result stream, and signals completion or timeout. It sits between a DMA/operand FIFO and the accelerator, so batch work runs without CPU involvement per command.

---
 rtl/accel_cmd_sequencer_if.sv | 45 ++++
 rtl/accel_cmd_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/accel_cmd_sequencer_if.sv
// Operand, command, response and result channels between the sequencer and its neighbours.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface accel_cmd_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data_0;
  logic [31:0] op_data_1;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_outputs_0;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;

  modport master (
    input  op_valid, op_data_0, op_data_1,
    output op_ready,
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1,
    input  cmd_ready,
    input  rsp_valid, rsp_outputs_0,
    output rsp_ready,
    output res_valid, res_data, res_last,
    input  res_ready
  );

  modport slave (
    output op_valid, op_data_0, op_data_1,
    input  op_ready,
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1,
    output cmd_ready,
    output rsp_valid, rsp_outputs_0,
    input  rsp_ready,
    input  res_valid, res_data, res_last,
    output res_ready
  );
endinterface

// File: rtl/accel_cmd_sequencer.sv
// Batch command sequencer: streams operand pairs to the accelerator under a credit limit,
// returns responses in order on a result stream, and aborts on a response timeout.
module accel_cmd_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [9:0]                   job_function_id,
  input  logic [CNT_W-1:0]             job_count,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  accel_cmd_sequencer_if.master        bus
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] received_q;
  logic [OutW-1:0]  outstanding_q;
  logic [TmoW-1:0]  tmo_q;

  logic [9:0]       func_q;
  logic             cmd_valid_q;
  logic [31:0]      cmd_in0_q;
  logic [31:0]      cmd_in1_q;

  logic             res_valid_q;
  logic             res_last_q;
  logic [31:0]      res_data_q;

  logic             busy_q;
  logic             done_q;
  logic             tmo_err_q;

  logic             load;
  logic             rsp_open;
  logic             rsp_fire;
  logic             rsp_run;
  logic             last_rsp;
  logic             tmo_hit;

  always_comb begin
    load     = (state_q == StRun) && (!cmd_valid_q || bus.cmd_ready) && bus.op_valid &&
               (issued_q < count_q) && (outstanding_q < OutW'(MAX_OUTSTANDING));
    rsp_open = !res_valid_q || bus.res_ready;
    rsp_fire = bus.rsp_valid && rsp_open;
    rsp_run  = rsp_fire && (state_q == StRun);
    last_rsp = rsp_run && ((received_q + 1'b1) == count_q);
    // An accepted response restarts the timer, so it can never coincide with an abort.
    tmo_hit  = (state_q == StRun) && (outstanding_q != '0) && !rsp_fire &&
               (tmo_q == TmoW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      tmo_q         <= '0;
      func_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_in0_q     <= '0;
      cmd_in1_q     <= '0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tmo_err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (cmd_valid_q && bus.cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
      if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (start) begin
            tmo_err_q <= 1'b0;
            if (job_count != '0) begin
              state_q       <= StRun;
              busy_q        <= 1'b1;
              func_q        <= job_function_id;
              count_q       <= job_count;
              issued_q      <= '0;
              received_q    <= '0;
              outstanding_q <= '0;
              tmo_q         <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        StRun: begin
          if (load) begin
            cmd_valid_q <= 1'b1;
            cmd_in0_q   <= bus.op_data_0;
            cmd_in1_q   <= bus.op_data_1;
            issued_q    <= issued_q + 1'b1;
          end

          if (rsp_run) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.rsp_outputs_0;
            res_last_q  <= last_rsp;
            received_q  <= received_q + 1'b1;
          end

          if (load && !rsp_run) begin
            outstanding_q <= outstanding_q + 1'b1;
          end else if (!load && rsp_run && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - 1'b1;
          end

          if (rsp_fire || (outstanding_q == '0)) begin
            tmo_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end

          // busy_q is left set so it covers the done cycle; IDLE clears it a cycle later.
          if (last_rsp) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (tmo_hit) begin
            state_q       <= StIdle;
            done_q        <= 1'b1;
            tmo_err_q     <= 1'b1;
            cmd_valid_q   <= 1'b0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            tmo_q         <= '0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout_err         = tmo_err_q;

  assign bus.op_ready        = load;
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_function_id = func_q;
  assign bus.cmd_inputs_0    = cmd_in0_q;
  assign bus.cmd_inputs_1    = cmd_in1_q;
  assign bus.rsp_ready       = rsp_open;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.res_last        = res_last_q;

endmodule
